mac_ctrl: RTL

- Sequencing/accumulate stage wrapped around the shared sequential 8x8 multiplier `mul`, which has a start/fin handshake and a 17-bit product.
- Accepts a stream of operand pairs on a valid/ready interface and issues one multiply per pair.
- Waits for `fin`, then accumulates the products into a dot-product sum.
- Presents the sum on a valid/ready output when the pair flagged `last` has been accumulated.

---
 rtl/mac_ctrl.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/mac_ctrl.sv
// ---------------------------------------------------------------------------
// mac_ctrl
//   Sequencing and accumulate stage wrapped around the shared sequential
//   8x8 multiplier. Each operand pair accepted on the input valid/ready
//   interface gets one multiply (start/fin handshake). The 17-bit product is
//   added into a saturating dot-product accumulator. When the pair flagged
//   'last' has been accumulated, the result is presented on the output
//   valid/ready interface. A multiply that never finishes is abandoned after
//   TMO+1 cycles of waiting, and the vector is then reported with out_err set.
//
// Parameters
//   ACCW : accumulator / out_sum width in bits (>= 17)
//   TMO  : last timer value tolerated in WAIT before timeout (1..255)
//
// Ports
//   ck        : clock, all logic on posedge
//   rst       : synchronous active-high reset
//   in_valid  : operand pair available          (in)
//   in_ready  : stage can accept a pair         (out, high exactly in IDLE)
//   in_a/in_b : operands                        (in, 8 bit)
//   in_last   : pair closes the vector          (in)
//   mul_a/b   : operands to the multiplier      (out, held START..ACC)
//   mul_start : one-cycle start pulse           (out)
//   mul_o     : multiplier product              (in, 17 bit)
//   mul_fin   : multiplier done pulse           (in, only honoured in WAIT)
//   out_valid : result available                (out)
//   out_ready : consumer accepts result         (in)
//   out_sum   : accumulated sum                 (out, ACCW bit)
//   out_cnt   : pairs accumulated, sat. at 255  (out)
//   out_ovf   : accumulator saturated in vector (out)
//   out_err   : vector aborted by mul timeout   (out)
// ---------------------------------------------------------------------------
module mac_ctrl #(
    parameter int ACCW = 24,
    parameter int TMO  = 63
) (
    input  logic            ck,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [7:0]      in_a,
    input  logic [7:0]      in_b,
    input  logic            in_last,
    output logic [7:0]      mul_a,
    output logic [7:0]      mul_b,
    output logic            mul_start,
    input  logic [16:0]     mul_o,
    input  logic            mul_fin,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ACCW-1:0] out_sum,
    output logic [7:0]      out_cnt,
    output logic            out_ovf,
    output logic            out_err
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ACC   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [7:0]      TMO_C   = 8'(TMO);
    localparam logic [ACCW-1:0] ACC_MAX = {ACCW{1'b1}};

    // Saturating accumulate. Bit ACCW of the result flags that the true sum
    // did not fit; the low ACCW bits are then clamped to all-ones.
    function automatic logic [ACCW:0] sat_add(input logic [ACCW-1:0] acc,
                                              input logic [16:0]     prod);
        logic [ACCW:0] prod_ext;
        logic [ACCW:0] wide;
        prod_ext        = {(ACCW+1){1'b0}};
        prod_ext[16:0]  = prod;
        wide            = {1'b0, acc} + prod_ext;
        if (wide[ACCW]) begin
            sat_add = {1'b1, ACC_MAX};
        end else begin
            sat_add = wide;
        end
    endfunction

    state_t          state_r;
    logic            last_r;
    logic [7:0]      timer_r;
    logic [16:0]     prod_r;
    logic [ACCW-1:0] acc_r;
    logic [7:0]      cnt_r;
    logic [ACCW:0]   acc_sum_s;

    // The stage is ready purely as a function of being idle.
    assign in_ready = (state_r == ST_IDLE);

    // Accumulator and count are presented directly; they only change in ACC,
    // so they are stable for the whole of DONE.
    assign out_sum = acc_r;
    assign out_cnt = cnt_r;

    // Next accumulator value (with saturation flag) for the ACC state.
    always_comb begin
        acc_sum_s = sat_add(acc_r, prod_r);
    end

    // Control FSM, datapath registers and all registered outputs.
    always_ff @(posedge ck) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            last_r    <= 1'b0;
            timer_r   <= 8'd0;
            prod_r    <= 17'd0;
            acc_r     <= {ACCW{1'b0}};
            cnt_r     <= 8'd0;
            mul_a     <= 8'd0;
            mul_b     <= 8'd0;
            mul_start <= 1'b0;
            out_valid <= 1'b0;
            out_ovf   <= 1'b0;
            out_err   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        mul_a     <= in_a;
                        mul_b     <= in_b;
                        last_r    <= in_last;
                        // Raised here so the pulse coincides with START.
                        mul_start <= 1'b1;
                        state_r   <= ST_START;
                    end
                end
                ST_START: begin
                    mul_start <= 1'b0;
                    timer_r   <= 8'd0;
                    state_r   <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A finish in the final tolerated cycle still wins over
                    // the timeout.
                    if (mul_fin) begin
                        prod_r  <= mul_o;
                        state_r <= ST_ACC;
                    end else if (timer_r == TMO_C) begin
                        // Abandon the vector; this pair is not counted.
                        out_err   <= 1'b1;
                        out_valid <= 1'b1;
                        state_r   <= ST_DONE;
                    end else begin
                        timer_r <= timer_r + 8'd1;
                    end
                end
                ST_ACC: begin
                    acc_r <= acc_sum_s[ACCW-1:0];
                    if (acc_sum_s[ACCW]) begin
                        out_ovf <= 1'b1;
                    end
                    if (cnt_r != 8'hFF) begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                    if (last_r) begin
                        out_valid <= 1'b1;
                        state_r   <= ST_DONE;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        acc_r     <= {ACCW{1'b0}};
                        cnt_r     <= 8'd0;
                        out_ovf   <= 1'b0;
                        out_err   <= 1'b0;
                        state_r   <= ST_IDLE;
                    end
                end
                default: begin
                    mul_start <= 1'b0;
                    out_valid <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
